div_prog: RTL

DIV_PROG -- requirements
Module: div_prog

---
 rtl/div_prog_pkg.sv | 14 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/div_prog.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/div_prog_pkg.sv
// Shared definitions for the programmable divisor front panel.
// - DIV_W        : width of the divisor value driven to the divider
// - rpt_state_t  : per-button auto-repeat state (idle, held, repeating)
package div_prog_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw button.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   level      : debounced level
//   rise       : one-cycle pulse in the cycle level goes 0 -> 1
module btn_debounce
    import div_prog_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             rise_reg;

    // cnt_reg counts consecutive synchronised samples that disagree with the
    // current debounced level; any agreeing sample clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b00;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], btn};
            rise_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                level_reg <= sync_reg[1];
                rise_reg  <= sync_reg[1];
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/div_prog.sv
// Push-button programmable divisor: up/down buttons with hold-to-repeat,
// a preset button, saturating arithmetic and a parallel-load strobe.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   btn_up, btn_dn, btn_pre : raw asynchronous buttons
//   coarse                  : selects STEP_COARSE (1) or STEP_FINE (0)
//   din                     : current divisor, always in [DIN_MIN, DIN_MAX]
//   pl                      : one-cycle load strobe, high when din changes
//                             and once on the first edge after reset
module div_prog
    import div_prog_pkg::*;
#(
    parameter int DEB_CYCLES  = 50000,
    parameter int RPT_DELAY   = 25000000,
    parameter int RPT_RATE    = 5000000,
    parameter int DIN_INIT    = 1000,
    parameter int DIN_MIN     = 1,
    parameter int DIN_MAX     = 65535,
    parameter int STEP_FINE   = 1,
    parameter int STEP_COARSE = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             btn_pre,
    input  logic             coarse,
    output logic [DIV_W-1:0] din,
    output logic             pl
);

    localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [DIV_W-1:0] INIT_VAL = DIV_W'(DIN_INIT);
    localparam logic [DIV_W-1:0] MIN_VAL  = DIV_W'(DIN_MIN);
    localparam logic [DIV_W-1:0] MAX_VAL  = DIV_W'(DIN_MAX);

    if (DIN_INIT < DIN_MIN || DIN_INIT > DIN_MAX) begin : g_bad_init
        $error("div_prog: DIN_INIT lies outside [DIN_MIN, DIN_MAX]");
    end

    // Button index: 0 = up, 1 = down, 2 = preset
    logic [2:0] btn_raw;
    logic [2:0] level;
    logic [2:0] rise;
    logic [1:0] rpt_ev;

    assign btn_raw = {btn_pre, btn_dn, btn_up};

    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_raw[gi]),
            .level(level[gi]),
            .rise (rise[gi])
        );
    end

    // Hold-to-repeat FSM for up and down. A debounced fall returns to idle
    // from any state and takes priority over a same-cycle repeat event.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
        rpt_state_t       state_reg;
        logic [RPT_W-1:0] cnt_reg;
        logic             ev_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                ev_reg    <= 1'b0;
            end else begin
                ev_reg <= 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (rise[gi]) begin
                            state_reg <= ST_HOLD;
                            cnt_reg   <= '0;
                            ev_reg    <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!level[gi]) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                        end else if (cnt_reg == RPT_W'(RPT_DELAY - 1)) begin
                            state_reg <= ST_RPT;
                            cnt_reg   <= '0;
                            ev_reg    <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (!level[gi]) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                        end else if (cnt_reg == RPT_W'(RPT_RATE - 1)) begin
                            cnt_reg <= '0;
                            ev_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end

        assign rpt_ev[gi] = ev_reg;
    end

    // Preset never repeats: one event per debounced rising edge.
    logic pre_ev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_ev_reg <= 1'b0;
        end else begin
            pre_ev_reg <= rise[2] & level[2];
        end
    end

    // Value arithmetic: the up sum is formed one bit wider so the clamp sees
    // overflow; the down path clamps at zero before applying DIN_MIN.
    logic [DIV_W-1:0] value_reg;
    logic [DIV_W-1:0] value_next;
    logic [DIV_W-1:0] step_w;
    logic [DIV_W:0]   sum_w;
    logic [DIV_W-1:0] up_val;
    logic [DIV_W-1:0] diff_w;
    logic [DIV_W-1:0] dn_val;
    logic             init_reg;
    logic             pl_reg;

    always_comb begin
        step_w     = coarse ? DIV_W'(STEP_COARSE) : DIV_W'(STEP_FINE);
        sum_w      = {1'b0, value_reg} + {1'b0, step_w};
        up_val     = (sum_w > {1'b0, MAX_VAL}) ? MAX_VAL : sum_w[DIV_W-1:0];
        diff_w     = (value_reg > step_w) ? (value_reg - step_w) : '0;
        dn_val     = (diff_w < MIN_VAL) ? MIN_VAL : diff_w;
        value_next = value_reg;
        if (pre_ev_reg) begin
            value_next = INIT_VAL;
        end else if (rpt_ev[0] && !rpt_ev[1]) begin
            value_next = up_val;
        end else if (rpt_ev[1] && !rpt_ev[0]) begin
            value_next = dn_val;
        end
    end

    // init_reg forces one load strobe on the first edge out of reset so the
    // downstream divider starts from DIN_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= INIT_VAL;
            pl_reg    <= 1'b0;
            init_reg  <= 1'b1;
        end else begin
            value_reg <= value_next;
            pl_reg    <= init_reg | (value_next != value_reg);
            init_reg  <= 1'b0;
        end
    end

    assign din = value_reg;
    assign pl  = pl_reg;

endmodule
